// File: rtl/control_pkg.sv
// Shared decode-side constants and the fetch queue entry layout.
package control_pkg;

  localparam int unsigned XLEN      = 64;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Instruction queue between fetch and decode: registered-state FIFO of (pc, instr)
// pairs with a NOP bubble when empty and pre-split decode fields on the head.
module fetch_buffer
  import control_pkg::fetch_entry_t;
  import control_pkg::NOP_INSTR;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [31:0]                in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [XLEN-1:0]            out_pc_plus4,
  output logic [31:0]                out_instr,
  output logic [6:0]                 opcode,
  output logic [2:0]                 funct3,
  output logic                       funct7b5,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fetch_buffer: DEPTH must be a power of 2 and at least 2");
  end
  if (XLEN != control_pkg::XLEN) begin : g_xlen_check
    $error("fetch_buffer: XLEN must match control_pkg::XLEN");
  end

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    head;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop, empty;

  assign empty     = (count_q == '0);
  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr};
  end

  // Bubble keys off occupancy alone so the outputs never expose unwritten storage.
  assign head         = mem_q[rd_ptr_q];
  assign out_instr    = empty ? NOP_INSTR : head.instr;
  assign out_pc       = empty ? '0 : head.pc;
  assign out_pc_plus4 = out_pc + XLEN'(4);
  assign opcode       = out_instr[6:0];
  assign funct3       = out_instr[14:12];
  assign funct7b5     = out_instr[30];

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed plus randomized checks of fetch_buffer against a queue-based model.
module tb_fetch_buffer;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid, funct7b5;
  logic [XLEN-1:0]   in_pc, out_pc, out_pc_plus4;
  logic [31:0]       in_instr, out_instr;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [2:0]        count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  ent_t        q[$];

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_plus4(out_pc_plus4), .out_instr(out_instr), .opcode(opcode),
    .funct3(funct3), .funct7b5(funct7b5), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the model queue and the current flush input.
  task automatic check_all(input string tag);
    logic [31:0] ei;
    logic [63:0] ep;
    ei = (q.size() != 0) ? q[0].instr : NOP;
    ep = (q.size() != 0) ? q[0].pc : 64'd0;
    chk({tag, ".out_valid"}, 64'(out_valid), 64'((q.size() != 0) && !flush));
    chk({tag, ".in_ready"},  64'(in_ready),  64'(q.size() != DEPTH));
    chk({tag, ".count"},     64'(count),     64'(q.size()));
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(ei));
    chk({tag, ".out_pc"},    out_pc,         ep);
    chk({tag, ".pc_plus4"},  out_pc_plus4,   ep + 64'd4);
    chk({tag, ".opcode"},    64'(opcode),    64'(ei[6:0]));
    chk({tag, ".funct3"},    64'(funct3),    64'(ei[14:12]));
    chk({tag, ".funct7b5"},  64'(funct7b5),  64'(ei[30]));
  endtask

  // Drive one cycle of inputs (called just after a falling edge), check, advance model.
  task automatic step(input string tag, input logic v, input logic [63:0] pc,
                      input logic [31:0] ins, input logic ordy, input logic fl);
    logic m_push, m_pop;
    in_valid = v; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl;
    #1;
    check_all(tag);
    m_push = v && (q.size() < DEPTH) && !fl;
    m_pop  = (q.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back('{pc, ins});
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #2;
    check_all("in_reset");
    chk("reset.plus4", out_pc_plus4, 64'd4);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    step("idle", 0, 0, 0, 0, 0);
    chk("idle.instr", 64'(out_instr), 64'h13);

    step("push1", 1, 64'h1000, 32'h00500093, 0, 0);
    chk("push1.valid", 64'(out_valid), 64'd1);
    chk("push1.pc", out_pc, 64'h1000);
    chk("push1.plus4", out_pc_plus4, 64'h1004);
    chk("push1.opcode", 64'(opcode), 64'h13);
    chk("push1.count", 64'(count), 64'd1);
    step("clr1", 0, 0, 0, 0, 1);

    for (int unsigned i = 0; i < 4; i++) step("fill", 1, 64'(i * 4), 32'h100 + i, 0, 0);
    chk("full.count", 64'(count), 64'd4);
    chk("full.in_ready", 64'(in_ready), 64'd0);
    step("fifth", 1, 64'h10, 32'hdead, 0, 0);
    chk("fifth.count", 64'(count), 64'd4);
    for (int unsigned i = 0; i < 4; i++) begin
      chk("drain.order", out_pc, 64'(i * 4));
      step("drain", 0, 0, 0, 1, 0);
      if (i == 0) chk("drain.in_ready", 64'(in_ready), 64'd1);
    end
    chk("drain.count", 64'(count), 64'd0);

    step("pp0", 1, 64'h500, 32'h00000033, 0, 0);
    step("pp1", 1, 64'h504, 32'h00000033, 0, 0);
    for (int unsigned i = 0; i < 10; i++) begin
      chk("pp.order", out_pc, 64'h500 + 64'(i * 4));
      step("pp", 1, 64'h508 + 64'(i * 4), 32'h00000033, 1, 0);
      chk("pp.count", 64'(count), 64'd2);
    end
    step("clr2", 0, 0, 0, 0, 1);

    for (int unsigned i = 0; i < 3; i++) step("pre_fl", 1, 64'h3000 + 64'(i * 4), 32'h13, 0, 0);
    step("flush_push", 1, 64'h2000, 32'h00100093, 1, 1);
    chk("flush.count", 64'(count), 64'd0);
    chk("flush.valid", 64'(out_valid), 64'd0);
    step("after_flush", 0, 0, 0, 0, 0);

    step("sub", 1, 64'hFFFFFFFFFFFFFFFC, 32'h40000033, 0, 0);
    chk("sub.plus4", out_pc_plus4, 64'd0);
    chk("sub.f7b5", 64'(funct7b5), 64'd1);
    chk("sub.opcode", 64'(opcode), 64'h33);
    step("sub_hold", 1, 64'h8, 32'h13, 0, 0);
    step("sub_hold2", 1, 64'hC, 32'h13, 0, 0);

    // Asynchronous reset mid-cycle with three entries held.
    #2 reset = 1'b1;
    #1 q.delete();
    check_all("async_rst");
    chk("async_rst.count", 64'(count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    step("post_rst", 0, 0, 0, 1, 0);

    for (int unsigned i = 0; i < 400; i++) begin
      logic [63:0] rpc;
      rpc = ($urandom % 8 == 0) ? 64'hFFFFFFFFFFFFFFF0 + 64'($urandom % 16)
                                : {$urandom, $urandom};
      step("rand", ($urandom % 4) != 0, rpc, $urandom, ($urandom % 3) != 0,
           ($urandom % 25) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
